// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the load/store controller: funct3 codes, FSM states
// and access-legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RMW_RD = 2'd1,
        ST_RMW_WR = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_t;

    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_H, F3_HU: ok = ~addr_lo[0];
            F3_W:        ok = (addr_lo == 2'b00);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Stores have no unsigned variants, so BU/HU are illegal with we=1.
    function automatic logic is_legal_f3(input logic we, input logic [2:0] funct3);
        logic ok;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core request/response and word-RAM signals of the load/store controller.
interface data_mem_ctrl_if #(parameter int ADDR_W = 32);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_we, ram_addr, ram_wdata
    );

    // Core plus RAM side.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/data_mem_ctrl_align.sv
// Combinational lane logic: load extract with sign/zero extension and
// sub-word store merge into an old RAM word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_ld_word,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    output logic [31:0] o_ld_data,
    input  logic [31:0] i_st_old,
    input  logic [15:0] i_st_data,
    input  logic [2:0]  i_st_funct3,
    input  logic [1:0]  i_st_addr_lo,
    output logic [31:0] o_st_word
);

    logic [31:0] w_ld_shift;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_rep;

    assign w_ld_shift = i_ld_word >> {i_ld_addr_lo, 3'b000};

    always_comb begin
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            F3_BU:   o_ld_data = {24'd0, w_ld_shift[7:0]};
            F3_H:    o_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            F3_HU:   o_ld_data = {16'd0, w_ld_shift[15:0]};
            default: o_ld_data = w_ld_shift;
        endcase
    end

    // Replicate the new data across all lanes, then let the byte enables pick.
    always_comb begin
        case (i_st_funct3)
            F3_B: begin
                w_st_be  = 4'b0001 << i_st_addr_lo;
                w_st_rep = {4{i_st_data[7:0]}};
            end
            F3_H: begin
                w_st_be  = 4'b0011 << i_st_addr_lo;
                w_st_rep = {2{i_st_data}};
            end
            default: begin
                w_st_be  = 4'b0000;
                w_st_rep = {2{i_st_data}};
            end
        endcase
        o_st_word = i_st_old;
        for (int b = 0; b < 4; b++) begin
            if (w_st_be[b]) o_st_word[8*b +: 8] = w_st_rep[8*b +: 8];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// RV32I load/store controller in front of a word-wide asynchronous-read RAM;
// sub-word stores are done as read-modify-write.
module data_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_ctrl_if.slave bus
);

    lsu_state_t        r_state;
    logic              r_ready;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic [2:0]        r_funct3;
    logic [31:0]       r_old;

    logic              w_accept;
    logic              w_legal;
    logic              w_sw;
    logic [31:0]       w_ld_data;
    logic [31:0]       w_st_word;

    assign w_accept = bus.req_valid & r_ready;
    assign w_legal  = is_legal_f3(bus.req_we, bus.req_funct3)
                    & is_aligned(bus.req_funct3, bus.req_addr[1:0]);
    assign w_sw     = w_accept & bus.req_we & w_legal & (bus.req_funct3 == F3_W);

    lsu_align u_align (
        .i_ld_word    (bus.ram_rdata),
        .i_ld_funct3  (bus.req_funct3),
        .i_ld_addr_lo (bus.req_addr[1:0]),
        .o_ld_data    (w_ld_data),
        .i_st_old     (r_old),
        .i_st_data    (r_wdata),
        .i_st_funct3  (r_funct3),
        .i_st_addr_lo (r_addr[1:0]),
        .o_st_word    (w_st_word)
    );

    // Reset gates the write strobe combinationally so an aborted RMW never lands.
    assign bus.ram_we    = reset & (w_sw | (r_state == ST_RMW_WR));
    assign bus.ram_addr  = (r_state == ST_IDLE) ? {bus.req_addr[ADDR_W-1:2], 2'b00}
                                                : {r_addr[ADDR_W-1:2], 2'b00};
    assign bus.ram_wdata = (r_state == ST_RMW_WR) ? w_st_word : bus.req_wdata;

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 16'd0;
            r_funct3    <= 3'd0;
            r_old       <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata[15:0];
                        r_funct3 <= bus.req_funct3;
                        r_ready  <= 1'b0;
                        if (!w_legal) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= 32'd0;
                            r_rsp_err   <= 1'b1;
                            r_state     <= ST_RESP;
                        end else if (!bus.req_we) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_ld_data;
                            r_rsp_err   <= 1'b0;
                            r_state     <= ST_RESP;
                        end else if (bus.req_funct3 == F3_W) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= 32'd0;
                            r_rsp_err   <= 1'b0;
                            r_state     <= ST_RESP;
                        end else begin
                            r_state <= ST_RMW_RD;
                        end
                    end
                end
                ST_RMW_RD: begin
                    r_old   <= bus.ram_rdata;
                    r_state <= ST_RMW_WR;
                end
                ST_RMW_WR: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= 32'd0;
                    r_rsp_err   <= 1'b0;
                    r_state     <= ST_RESP;
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl with a behavioural word RAM and a
// reference memory image.
module tb_data_mem_ctrl;
    import lsu_pkg::*;

    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    assign bus.ram_rdata = mem[bus.ram_addr[7:2]];
    always @(posedge clk) if (bus.ram_we === 1'b1) mem[bus.ram_addr[7:2]] <= bus.ram_wdata;

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check_val("rsp_rdata", bus.rsp_rdata, e[31:0]);
                check_val("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e[32]});
            end
        end
    end

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        if (we) begin
            if (f3 == 3'd0) return 1'b0;
            if (f3 == 3'd1) return lo[0];
            if (f3 == 3'd2) return lo != 2'b00;
            return 1'b1;
        end
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) return lo[0];
        if (f3 == 3'd2) return lo != 2'b00;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lo +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    return 32'($signed(b));
            3'd4:    return {24'd0, b};
            3'd1:    return 32'($signed(h));
            3'd5:    return {16'd0, h};
            default: return word;
        endcase
    endfunction

    // Issues one request, predicts its response and checks latency and the
    // per-cycle ram_we pattern (bit i = cycle i after the accept cycle 0).
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag);
        logic        err;
        logic [31:0] rd;
        int          exp_lat;
        int          lat;
        logic [3:0]  exp_map;
        logic [3:0]  map;
        int          idx;
        idx = int'(addr[7:2]);
        err = ref_err(we, f3, addr[1:0]);
        rd = 32'd0;
        exp_lat = 1;
        exp_map = 4'b0000;
        if (!err && !we) begin
            rd = ref_load(ref_mem[idx], f3, addr[1:0]);
        end else if (!err && f3 == 3'd2) begin
            exp_map = 4'b0001;
            ref_mem[idx] = wd;
        end else if (!err) begin
            exp_lat = 3;
            exp_map = 4'b0100;
            if (f3 == 3'd0) ref_mem[idx][8*addr[1:0] +: 8] = wd[7:0];
            else            ref_mem[idx][16*addr[1] +: 16] = wd[15:0];
        end
        map = 4'b0000;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        #1;
        check_val({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        map[0] = bus.ram_we;
        exp_q.push_back({err, rd});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i < 4) map[i] = bus.ram_we;
            if (bus.rsp_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_we"}, {28'd0, map}, {28'd0, exp_map});
    endtask

    // Starts an SB to 0x10 and pulls reset low in cycle cyc after accept.
    task automatic rst_abort(input int cyc, input string tag);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_B;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'h55;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int i = 1; i < cyc; i++) begin
            @(negedge clk);
            check_val({tag, "_we_pre"}, {31'd0, bus.ram_we}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1 check_val({tag, "_we_rst"}, {31'd0, bus.ram_we}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check_val({tag, "_we_hold"}, {31'd0, bus.ram_we}, 32'd0);
        end
        reset = 1'b1;
        #1;
        check_val({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        check_val({tag, "_word"}, mem[4], ref_mem[4]);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        check_val("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check_val("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_val("rst_rdata", bus.rsp_rdata, 32'd0);
        check_val("rst_err", {31'd0, bus.rsp_err}, 32'd0);
        check_val("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_val("rst_word", mem[4], 32'd0);

        do_req(1'b1, F3_W,  32'h10, 32'h12345678, "sw");
        do_req(1'b0, F3_W,  32'h10, 32'h0,        "lw");
        do_req(1'b1, F3_B,  32'h11, 32'h000000AB, "sb");
        check_val("sb_word", mem[4], 32'h1234AB78);
        do_req(1'b0, F3_B,  32'h11, 32'h0, "lb");
        do_req(1'b0, F3_BU, 32'h11, 32'h0, "lbu");
        do_req(1'b1, F3_H,  32'h12, 32'hFFFF8001, "sh");
        check_val("sh_word", mem[4], 32'h8001AB78);
        do_req(1'b0, F3_H,  32'h12, 32'h0, "lh");
        do_req(1'b0, F3_HU, 32'h12, 32'h0, "lhu");
        do_req(1'b0, F3_B,  32'h13, 32'h0, "lb3");
        do_req(1'b0, F3_HU, 32'h10, 32'h0, "lhu0");

        do_req(1'b0, F3_W,  32'h13, 32'h0,      "err_lw");
        do_req(1'b1, F3_H,  32'h11, 32'h0000BEEF, "err_sh");
        do_req(1'b0, 3'd3,  32'h10, 32'h0,      "err_f3");
        do_req(1'b1, F3_W,  32'h12, 32'hCAFEF00D, "err_sw");
        do_req(1'b1, F3_BU, 32'h10, 32'h77,     "err_sbu");
        check_val("err_word", mem[4], 32'h8001AB78);

        // Back-to-back with req_valid held: SB then LW.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_B;
        bus.req_addr   = 32'h13;
        bus.req_wdata  = 32'h000000CD;
        ref_mem[4][31:24] = 8'hCD;
        exp_q.push_back({1'b0, 32'd0});
        exp_q.push_back({1'b0, ref_mem[4]});
        @(posedge clk);
        #1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h10;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check_val("b2b_ready_busy", {31'd0, bus.req_ready}, 32'd0);
        end
        @(negedge clk);
        check_val("b2b_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check_val("b2b_lw_rsp", {31'd0, bus.rsp_valid}, 32'd1);
        check_val("b2b_word", mem[4], 32'hCD01AB78);

        rst_abort(1, "rst_rd");
        do_req(1'b0, F3_W, 32'h10, 32'h0, "lw_after_rd");
        rst_abort(2, "rst_wr");
        do_req(1'b0, F3_W, 32'h10, 32'h0, "lw_after_wr");

        repeat (3) @(negedge clk);
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 8; i++) check_val("final_mem", mem[i], ref_mem[i]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Load/store controller between the RV32I core's data port and the word-wide data RAM in the MCU top. It takes one load or store request at a time from the core, does RV32I byte, halfword and word load extraction with sign/zero extension, and performs sub-word stores as a read-modify-write on the 32-bit RAM. Misaligned and illegal-width accesses are reported instead of executed. The block owns all RAM write-enable generation.

## Interface
- `ADDR_W`, default 32: width of the core address and the RAM address.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low; sampled on the rising edge of `clk`.
- `req_valid`  in  1: the core presents a request.
- `req_ready`  out  1: the controller can accept a request.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RV32I funct3 (access width and signedness).
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data, right-aligned.
- `rsp_valid`  out  1: one-cycle completion pulse.
- `rsp_rdata`  out  32: load result after extension; 0 for stores and errors.
- `rsp_err`  out  1: misaligned address or illegal funct3; valid while `rsp_valid` is high.
- `ram_we`  out  1: RAM write enable.
- `ram_addr`  out  ADDR_W: word-aligned RAM address (bits [1:0] are always 0).
- `ram_wdata`  out  32: RAM write word.
- `ram_rdata`  in  32: RAM read word, asynchronous read.

## Operation
- States:
  - IDLE: `req_ready` = 1.
  - RMW_RD: latches the old word.
  - RMW_WR: writes the merged word.
  - RESP: `rsp_valid` = 1, `req_ready` = 0.
- A request is accepted when `req_valid` and `req_ready` are both high, in IDLE only.
- While in IDLE, `ram_addr` = {`req_addr`[ADDR_W-1:2], 2'b00}, driven combinationally.
- In all other states, `ram_addr` uses the latched address.
- Legal accesses:
  - Loads: LB=0, LH=1, LW=2, LBU=4, LHU=5.
  - Stores: SB=0, SH=1, SW=2.
- Error conditions:
  - Any other funct3 value.
  - Halfword access with `addr`[0]=1.
  - Word access with `addr`[1:0]≠0.
  - On error: accept → RESP with `rsp_err`=1 and `rsp_rdata`=0. `ram_we` is never asserted.
- Load: on acceptance, select the byte or halfword lane of `ram_rdata` by `addr`[1:0], extend it (sign for LB/LH, zero for LBU/LHU), register it into `rsp_rdata`, then go to RESP.
- SW: `ram_we`=1 in the accept cycle with `ram_wdata`=`req_wdata`, then go to RESP.
- SB/SH:
  - Accept cycle: latch address, data and funct3, then go to RMW_RD.
  - RMW_RD: register `ram_rdata`.
  - RMW_WR: `ram_we`=1 with the merged word. Replace only the addressed lane; all other bytes keep their old value.
  - Then go to RESP.
- RESP always returns to IDLE.
- `ram_we` is gated by `reset`: it is 0 in any cycle where `reset`=0.

## Timing
- Reset values: state=IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, latched registers=0.
- After reset: `req_ready`=1 and `ram_we`=0.
- Latency from the accept edge to `rsp_valid`:
  - Load, SW, error: 1 cycle.
  - SB/SH: 3 cycles.
- Throughput: at most one request per 2 cycles; 4 cycles for sub-word stores.
- `req_*` inputs are ignored outside IDLE. A `req_valid` held high is accepted in the first IDLE cycle.
- `rsp_rdata` and `rsp_err` hold their value until the next response.
- Reset asserted mid-RMW:
  - The store is aborted and the RAM is left unmodified, including when reset is asserted in the RMW_WR cycle.
  - The next state is IDLE.

## Structure
- `lsu_pkg`:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum `lsu_state_t`.
  - Helper function `is_aligned(funct3, addr_lo)`.
- One combinational sub-module, `lsu_align`:
  - Load lane extract with extension.
  - Store lane merge (old word, new data, `addr`[1:0], funct3 → merged word).
  - Shared by the load path and RMW_WR.

## Test plan
- SW 0x12345678 to 0x10 → `ram_we`=1 in the accept cycle; then LW 0x10 → `rsp_rdata`=0x12345678 one cycle after accept, `rsp_err`=0.
- SB 0xAB to 0x11 → `ram_we` only in cycle 2 after accept, word=0x1234AB78; LB 0x11 → 0xFFFFFFAB; LBU 0x11 → 0x000000AB.
- SH 0x8001 to 0x12 → word=0x8001AB78; LH 0x12 → 0xFFFF8001; LHU 0x12 → 0x00008001.
- LW 0x13, SH 0x11, load funct3=3 → each gives `rsp_err`=1 and `rsp_rdata`=0; `ram_we` never high; word 0x10 unchanged.
- `req_valid` held high across back-to-back SB + LW → `req_ready`=0 during RMW_RD, RMW_WR and RESP; LW accepted in the first IDLE cycle and returns the merged word.
- `reset`=0 during RMW_RD, and separately during RMW_WR → `ram_we`=0 throughout, word unchanged, IDLE with `req_ready`=1 after `reset` returns to 1.
